// File: rtl/rtrt_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rtrt_fb_pkg
// Purpose  : Shared types and VGA timing constants for the frame-buffer
//            scanout path.
//            rgb444_t  - packed {r,g,b} 4-bit colour
//            H_/V_*    - 640x480 visible area inside an 800x525 raster
// Revision : 1.0 - initial release
// ============================================================================
package rtrt_fb_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

endpackage
`default_nettype wire

// File: rtl/fb_addr_calc.sv
`default_nettype none
// ============================================================================
// Module   : fb_addr_calc
// Purpose  : Combinational frame-buffer address, addr = y*FB_W + x,
//            truncated to 16 bits.
// Ports    : i_x    [9:0]  pixel column
//            i_y    [9:0]  pixel row
//            o_addr [15:0] linear word address
// Revision : 1.0 - initial release
// ============================================================================
module fb_addr_calc #(
  parameter int FB_W = 160
) (
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  output logic [15:0] o_addr
);

  logic [15:0] w_x16;
  logic [15:0] w_y16;

  assign w_x16 = {6'd0, i_x};
  assign w_y16 = {6'd0, i_y};

  generate
    if (FB_W == 160) begin : g_shift
      // 160 = 128 + 32, so two shifts and an add replace the multiplier.
      assign o_addr = (w_y16 << 7) + (w_y16 << 5) + w_x16;
    end else begin : g_mult
      assign o_addr = w_y16 * 16'(FB_W) + w_x16;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : fb_scanout
// Purpose  : Scans an FB_W x FB_H RGB444 frame buffer out to VGA with a
//            2**SCALE_LOG2 upscale, sharing the single-port OCM with the
//            ray-tracing cores' write port. Reads take one-cycle slots;
//            every other cycle is granted to the writer.
// Ports    : CLK, RESET_N (async, active-low)
//            DRAW_X/DRAW_Y/BLANK        - VGA timing generator inputs
//            WR_VALID/WR_READY/WR_X/WR_Y/WR_RGB - RT-core write port
//            OCM_ADDR/OCM_DATAIN/OCM_WE/OCM_DATAOUT - frame-buffer RAM
//            VGA_R/VGA_G/VGA_B          - pixel colour
// Config   : FB_BOUNDS_CHECK_EN - drop (grant but do not write) writes
//            outside the FB_W x FB_H buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fb_scanout
  import rtrt_fb_pkg::*;
#(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [9:0]  DRAW_X,
  input  logic [9:0]  DRAW_Y,
  input  logic        BLANK,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [7:0]  WR_X,
  input  logic [6:0]  WR_Y,
  input  logic [11:0] WR_RGB,
  output logic [15:0] OCM_ADDR,
  output logic [15:0] OCM_DATAIN,
  output logic        OCM_WE,
  input  logic [15:0] OCM_DATAOUT,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B
);

  localparam logic [9:0] c_last_col = 10'(FB_W - 1);

  logic [9:0]  r_prev_x;
  logic        r_rd_slot;
  logic        r_rd_cap;
  logic [15:0] r_rd_addr;
  logic        r_rd_idx;
  rgb444_t     r_buf [2];

  logic        w_chg;
  logic [9:0]  w_col;
  logic [9:0]  w_next_y;
  logic        w_col_pf;
  logic        w_line_pf;
  logic        w_rd_trig;
  logic [9:0]  w_rd_x;
  logic [9:0]  w_rd_y;
  logic        w_rd_idx;
  logic [15:0] w_rd_addr;
  logic [15:0] w_wr_addr;
  logic        w_in_bounds;
  rgb444_t     w_pix;
  logic        w_unused;

  // Each DRAW_X value lasts two cycles; only its first cycle may trigger.
  assign w_chg    = (DRAW_X != r_prev_x);
  assign w_col    = DRAW_X >> SCALE_LOG2;
  assign w_next_y = (DRAW_Y == 10'(V_TOTAL - 1)) ? 10'd0 : DRAW_Y + 10'd1;

  // Fetch column c+1 one pixel into column c so it lands well before use.
  assign w_col_pf = w_chg
                 && (DRAW_X[SCALE_LOG2-1:0] == SCALE_LOG2'(1))
                 && (DRAW_X < 10'(H_VISIBLE))
                 && (DRAW_Y < 10'(V_VISIBLE))
                 && (w_col < c_last_col);

  // Column 0 of the upcoming line is fetched at the end of horizontal blank.
  assign w_line_pf = w_chg
                  && (DRAW_X == 10'(H_TOTAL - 1))
                  && (w_next_y < 10'(V_VISIBLE));

  assign w_rd_trig = w_col_pf | w_line_pf;
  assign w_rd_x    = w_line_pf ? 10'd0 : w_col + 10'd1;
  assign w_rd_y    = w_line_pf ? (w_next_y >> SCALE_LOG2) : (DRAW_Y >> SCALE_LOG2);
  assign w_rd_idx  = w_line_pf ? 1'b0 : w_rd_x[0];

  fb_addr_calc #(.FB_W(FB_W)) u_rd_addr (
    .i_x    (w_rd_x),
    .i_y    (w_rd_y),
    .o_addr (w_rd_addr)
  );

  fb_addr_calc #(.FB_W(FB_W)) u_wr_addr (
    .i_x    ({2'b00, WR_X}),
    .i_y    ({3'b000, WR_Y}),
    .o_addr (w_wr_addr)
  );

`ifdef FB_BOUNDS_CHECK_EN
  assign w_in_bounds = ({2'b00, WR_X} < 10'(FB_W)) && ({3'b000, WR_Y} < 10'(FB_H));
  assign w_unused    = ^OCM_DATAOUT[15:12];
`else
  assign w_in_bounds = 1'b1;
  assign w_unused    = ^{OCM_DATAOUT[15:12], 10'(FB_H)};
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_prev_x  <= '0;
      r_rd_slot <= 1'b0;
      r_rd_cap  <= 1'b0;
      r_rd_addr <= '0;
      r_rd_idx  <= 1'b0;
      r_buf[0]  <= '0;
      r_buf[1]  <= '0;
    end else begin
      r_prev_x  <= DRAW_X;
      r_rd_slot <= w_rd_trig;
      r_rd_cap  <= r_rd_slot;
      if (w_rd_trig) begin
        r_rd_addr <= w_rd_addr;
        r_rd_idx  <= w_rd_idx;
      end
      // RAM data arrives the cycle after the address slot.
      if (r_rd_cap) begin
        r_buf[r_rd_idx] <= OCM_DATAOUT[11:0];
      end
    end
  end

  // Outputs are forced to zero while reset is held, independent of the clock.
  assign WR_READY   = RESET_N & ~r_rd_slot;
  assign OCM_WE     = WR_READY & WR_VALID & w_in_bounds;
  assign OCM_ADDR   = !RESET_N ? 16'd0 : (r_rd_slot ? r_rd_addr : w_wr_addr);
  assign OCM_DATAIN = RESET_N ? {4'b0000, WR_RGB} : 16'd0;

  assign w_pix = r_buf[w_col[0]];
  assign VGA_R = BLANK ? w_pix.r : 4'd0;
  assign VGA_G = BLANK ? w_pix.g : 4'd0;
  assign VGA_B = BLANK ? w_pix.b : 4'd0;

endmodule
`default_nettype wire
